branch_checkpoint_ctrl: RTL and testbench
=========================================

Name: branch_checkpoint_ctrl

Overview:
- Scheduler for the RAT checkpoint buffer of the out-of-order core.
- Allocates a checkpoint slot (tag) to each dispatched branch or jump and tells the RAT when to snapshot.
- On out-of-order branch resolution, retires correct checkpoints in order. On a mispredict it drives the RAT restore, flushes younger slots and holds dispatch during recovery.
- Sits between decode/dispatch, the branch execute unit and the RAT/freelist.

Parameters:
- DEPTH, 8, number of checkpoint slots; must be a power of 2.
- TAG_W, 3, log2(DEPTH).
- RECOVER_CYC, 2, cycles dispatch is held after a RAT restore; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_req  in  1  dispatch presents a branch/jump (opcode 1100011/1101111/1100111).
- alloc_pc  in  32  PC of that instruction.
- alloc_grant  out  1  combinational; slot granted this cycle.
- alloc_tag  out  TAG_W  combinational; tag granted (current tail).
- copy_rat  out  1  registered pulse; RAT snapshots into copy_tag.
- copy_tag  out  TAG_W  slot for the snapshot.
- resolve_valid  in  1  branch unit resolves one checkpoint.
- resolve_tag  in  TAG_W  tag being resolved.
- resolve_mispredict  in  1  1 = taken/redirect (PCSrc), restore needed.
- exception_sig  in  1  flush everything.
- mret_sig  in  1  flush everything.
- paste_rat  out  1  registered pulse; RAT restores from paste_tag.
- paste_tag  out  TAG_W  slot to restore.
- flush_mask  out  DEPTH  registered one-hot-per-slot set of invalidated younger slots, valid with paste_rat.
- recover_busy  out  1  dispatch stall during recovery.
- full  out  1  count == DEPTH.
- count  out  TAG_W+1  live slots.
- oldest_pc  out  32  PC in head slot; 0 when empty.
- resolve_err  out  1  sticky; resolve to a non-live slot seen.

Behaviour:
- State per slot: valid, resolved, pc[31:0]. Pointers head and tail are TAG_W bits and wrap modulo DEPTH. count is registered.
- Reset (rst low, async): all slot bits and pc cleared, head = tail = 0, count = 0, state IDLE. All outputs are 0.
- FSM:
  - IDLE.
  - RECOVER: entered the cycle after a mispredict resolve. Stays RECOVER_CYC cycles via a down-counter, then returns to IDLE.
- alloc_grant = alloc_req & !full & state==IDLE & !resolve_mispredict_hit & !exception_sig & !mret_sig.
- On grant: slot[tail] is written valid, pc = alloc_pc, resolved = 0; tail increments. Next cycle copy_rat = 1 and copy_tag = granted tag.
- Resolve, correct (mispredict = 0, slot valid): slot.resolved <= 1.
- Retire: each cycle, if slot[head] is valid and resolved, it is cleared and head increments. At most one retire per cycle. Retire uses the state before any same-cycle resolve, so a resolve-then-retire takes 2 cycles.
- Resolve, mispredict (slot valid) = resolve_mispredict_hit. Next cycle:
  - paste_rat = 1 and paste_tag = resolve_tag.
  - flush_mask = all valid slots strictly younger than resolve_tag (tag+1 up to tail-1, wrapping).
  - Those slots and slot[resolve_tag] itself are cleared; tail <= resolve_tag.
  - FSM goes to RECOVER and recover_busy = 1 for RECOVER_CYC cycles.
- Mispredict on the head slot: all slots clear, head unchanged, tail = head.
- Resolve to a non-valid slot: ignored; resolve_err <= 1 until reset.
- exception_sig or mret_sig: highest priority. Next cycle all slots clear, head = tail = 0, FSM IDLE, no paste_rat, recover_busy = 0. Same-cycle alloc and resolve are dropped.
- Same-cycle priority: exception/mret > mispredict > alloc. A grant and a retire in the same cycle are legal; count is adjusted by +1−1.
- full uses registered count, so no grant when full even if head retires that cycle.
- count = tail − head modulo DEPTH, with full disambiguated by a wrap bit.
- copy_rat and paste_rat are never high in the same cycle, because a grant is blocked on a mispredict.

Decomposition:
- Shared package (core_pkg): opcode constants for BRANCH/JAL/JALR, TAG_W/DEPTH defaults, the slot struct typedef (valid, resolved, pc), and the FSM state enum.
- One sub-module, ckpt_age_mask: combinational; from head, tail and a tag it produces the DEPTH-bit younger-than mask, handling wrap.

Test Plan:
1. Reset, then alloc 3 branches at PCs 0x100/0x104/0x108 → tags 0,1,2; copy_rat pulses one cycle later each; count = 3; oldest_pc = 0x100.
2. Resolve tag 1 correct, then tag 0 correct → no retire after the tag-1 resolve; then head retires 0 then 1 on consecutive cycles; count goes 3 → 2 → 1.
3. 8 allocs, full = 1; a 9th alloc_req → alloc_grant = 0. Resolve tag 0 correct → one cycle later full = 0 and the next alloc gets tag 0 (wrap).
4. Tags 0..4 live; mispredict on tag 2 → next cycle paste_rat = 1, paste_tag = 2, flush_mask = 0x18; tail = 2; recover_busy high 2 cycles; alloc_req during busy is not granted.
5. Alloc, mispredict and exception_sig in the same cycle → no grant, no paste_rat; next cycle count = 0, head = tail = 0.
6. Resolve to an empty tag 5 → state unchanged and resolve_err = 1; assert rst low mid-RECOVER → all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the branch checkpoint logic.
//               Holds the control-transfer opcodes, the default checkpoint
//               geometry, the per-slot record and the scheduler state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Control-transfer opcodes that dispatch turns into checkpoint requests
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    // Default checkpoint geometry
    localparam int c_DEPTH_DEF = 8;
    localparam int c_TAG_W_DEF = 3;

    // One checkpoint slot
    typedef struct packed {
        logic        valid;
        logic        resolved;
        logic [31:0] pc;
    } slot_t;

    // Scheduler state, explicit 1-bit encoding
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    // True when the opcode needs a RAT checkpoint
    function automatic logic is_ctrl_op(input logic [6:0] opc);
        return (opc == c_OPC_BRANCH) || (opc == c_OPC_JAL) || (opc == c_OPC_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ckpt_age_mask.sv
`default_nettype none
// ============================================================================
// Module      : ckpt_age_mask
// Description : Combinational younger-than mask. Marks every live slot that
//               is strictly younger than i_tag, where age is measured from
//               the head pointer so that pointer wrap is handled naturally.
// Ports       : i_head, i_tail - ring pointers
//               i_full         - disambiguates head == tail (full vs empty)
//               i_tag          - reference slot
//               o_mask         - one bit per slot, 1 = younger than i_tag
// Revision    : 1.0 - initial release
// ============================================================================
module ckpt_age_mask #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic [TAG_W-1:0] i_head,
    input  logic [TAG_W-1:0] i_tail,
    input  logic             i_full,
    input  logic [TAG_W-1:0] i_tag,
    output logic [DEPTH-1:0] o_mask
);

    logic [TAG_W:0]   w_live_len;
    logic [TAG_W-1:0] w_tag_age;

    // head == tail is ambiguous on its own; the full flag picks DEPTH over 0
    assign w_live_len = i_full ? (TAG_W+1)'(DEPTH) : {1'b0, i_tail - i_head};
    assign w_tag_age  = i_tag - i_head;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [TAG_W-1:0] w_age;
            assign w_age      = TAG_W'(gi) - i_head;
            assign o_mask[gi] = (w_age > w_tag_age) && ({1'b0, w_age} < w_live_len);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/branch_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_checkpoint_ctrl
// Description : Scheduler for the RAT checkpoint ring. Hands a tag to each
//               dispatched branch/jump, asks the RAT to snapshot, retires
//               correctly resolved checkpoints in order, and on a mispredict
//               requests a RAT restore, flushes younger slots and stalls
//               dispatch for RECOVER_CYC cycles.
// Ports       : clk/rst                 - clock, async active-low reset
//               alloc_*                 - dispatch request / grant / tag
//               copy_rat, copy_tag      - RAT snapshot request (registered)
//               resolve_*               - branch unit resolution
//               exception_sig, mret_sig - full flush
//               paste_rat, paste_tag,
//               flush_mask              - RAT restore request (registered)
//               recover_busy            - dispatch stall
//               full, count, oldest_pc  - ring status
//               resolve_err             - sticky bad-resolve flag
// Revision    : 1.0 - initial release
// ============================================================================
module branch_checkpoint_ctrl
    import core_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TAG_W       = 3,
    parameter int RECOVER_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    input  logic [31:0]      alloc_pc,
    output logic             alloc_grant,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             copy_rat,
    output logic [TAG_W-1:0] copy_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_mispredict,
    input  logic             exception_sig,
    input  logic             mret_sig,
    output logic             paste_rat,
    output logic [TAG_W-1:0] paste_tag,
    output logic [DEPTH-1:0] flush_mask,
    output logic             recover_busy,
    output logic             full,
    output logic [TAG_W:0]   count,
    output logic [31:0]      oldest_pc,
    output logic             resolve_err
);

    slot_t            r_slots [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;
    state_t           r_state;
    logic [3:0]       r_rcnt;
    logic             r_copy_rat;
    logic [TAG_W-1:0] r_copy_tag;
    logic             r_paste_rat;
    logic [TAG_W-1:0] r_paste_tag;
    logic [DEPTH-1:0] r_flush_mask;
    logic             r_resolve_err;

    logic             w_flush_all;
    logic             w_res_live;
    logic             w_mp_hit;
    logic             w_ok_hit;
    logic             w_full;
    logic             w_grant;
    logic             w_retire;
    logic [TAG_W-1:0] w_head_next;
    logic [DEPTH-1:0] w_young_mask;
    slot_t            w_head_slot;

    assign w_flush_all = exception_sig | mret_sig;
    assign w_res_live  = r_slots[resolve_tag].valid;
    assign w_mp_hit    = resolve_valid & resolve_mispredict  & w_res_live & ~w_flush_all;
    assign w_ok_hit    = resolve_valid & ~resolve_mispredict & w_res_live & ~w_flush_all;
    assign w_full      = (r_count == (TAG_W+1)'(DEPTH));
    assign w_grant     = alloc_req & ~w_full & (r_state == ST_IDLE) & ~w_mp_hit & ~w_flush_all;
    assign w_head_slot = r_slots[r_head];

    // A mispredict on the head wipes the ring and leaves head in place, so
    // the head must not also advance in that cycle.
    assign w_retire    = w_head_slot.valid & w_head_slot.resolved & ~w_flush_all
                         & ~(w_mp_hit && (resolve_tag == r_head));
    assign w_head_next = r_head + TAG_W'(w_retire);

    ckpt_age_mask #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_age_mask (
        .i_head (r_head),
        .i_tail (r_tail),
        .i_full (w_full),
        .i_tag  (resolve_tag),
        .o_mask (w_young_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_state       <= ST_IDLE;
            r_rcnt        <= '0;
            r_copy_rat    <= 1'b0;
            r_copy_tag    <= '0;
            r_paste_rat   <= 1'b0;
            r_paste_tag   <= '0;
            r_flush_mask  <= '0;
            r_resolve_err <= 1'b0;
        end else if (w_flush_all) begin
            for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_state      <= ST_IDLE;
            r_rcnt       <= '0;
            r_copy_rat   <= 1'b0;
            r_paste_rat  <= 1'b0;
            r_flush_mask <= '0;
        end else begin
            r_copy_rat   <= w_grant;
            r_paste_rat  <= w_mp_hit;
            r_flush_mask <= w_mp_hit ? w_young_mask : '0;
            if (w_grant)  r_copy_tag  <= r_tail;
            if (w_mp_hit) r_paste_tag <= resolve_tag;
            if (resolve_valid && !w_res_live) r_resolve_err <= 1'b1;

            if (w_ok_hit) r_slots[resolve_tag].resolved <= 1'b1;
            if (w_retire) r_slots[r_head] <= '0;
            r_head <= w_head_next;

            if (w_mp_hit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_young_mask[i] || (TAG_W'(i) == resolve_tag)) r_slots[i] <= '0;
                end
                r_tail  <= resolve_tag;
                r_count <= {1'b0, resolve_tag - w_head_next};
            end else begin
                if (w_grant) begin
                    r_slots[r_tail] <= '{valid: 1'b1, resolved: 1'b0, pc: alloc_pc};
                    r_tail          <= r_tail + 1'b1;
                end
                r_count <= r_count + (TAG_W+1)'(w_grant) - (TAG_W+1)'(w_retire);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_mp_hit) begin
                        r_state <= ST_RECOVER;
                        r_rcnt  <= 4'(RECOVER_CYC - 1);
                    end
                end
                ST_RECOVER: begin
                    if (w_mp_hit) begin
                        r_rcnt <= 4'(RECOVER_CYC - 1);
                    end else if (r_rcnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rcnt <= r_rcnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alloc_grant  = w_grant;
    assign alloc_tag    = r_tail;
    assign copy_rat     = r_copy_rat;
    assign copy_tag     = r_copy_tag;
    assign paste_rat    = r_paste_rat;
    assign paste_tag    = r_paste_tag;
    assign flush_mask   = r_flush_mask;
    assign recover_busy = (r_state == ST_RECOVER);
    assign full         = w_full;
    assign count        = r_count;
    assign oldest_pc    = w_head_slot.valid ? w_head_slot.pc : 32'd0;
    assign resolve_err  = r_resolve_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_checkpoint_ctrl
// Description : Directed self-checking bench for branch_checkpoint_ctrl.
//               Inputs change 1 ns after the rising edge; outputs are
//               compared in the same window, away from the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_checkpoint_ctrl;

    localparam int c_DEPTH = 8;
    localparam int c_TAG_W = 3;

    logic               clk;
    logic               rst;
    logic               alloc_req;
    logic [31:0]        alloc_pc;
    logic               alloc_grant;
    logic [c_TAG_W-1:0] alloc_tag;
    logic               copy_rat;
    logic [c_TAG_W-1:0] copy_tag;
    logic               resolve_valid;
    logic [c_TAG_W-1:0] resolve_tag;
    logic               resolve_mispredict;
    logic               exception_sig;
    logic               mret_sig;
    logic               paste_rat;
    logic [c_TAG_W-1:0] paste_tag;
    logic [c_DEPTH-1:0] flush_mask;
    logic               recover_busy;
    logic               full;
    logic [c_TAG_W:0]   count;
    logic [31:0]        oldest_pc;
    logic               resolve_err;

    int n_checks = 0;
    int n_errors = 0;

    branch_checkpoint_ctrl #(
        .DEPTH       (c_DEPTH),
        .TAG_W       (c_TAG_W),
        .RECOVER_CYC (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_req          (alloc_req),
        .alloc_pc           (alloc_pc),
        .alloc_grant        (alloc_grant),
        .alloc_tag          (alloc_tag),
        .copy_rat           (copy_rat),
        .copy_tag           (copy_tag),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .exception_sig      (exception_sig),
        .mret_sig           (mret_sig),
        .paste_rat          (paste_rat),
        .paste_tag          (paste_tag),
        .flush_mask         (flush_mask),
        .recover_busy       (recover_busy),
        .full               (full),
        .count              (count),
        .oldest_pc          (oldest_pc),
        .resolve_err        (resolve_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic alloc_n(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            alloc_req = 1'b1;
            alloc_pc  = base + 32'(4 * k);
            step();
        end
        alloc_req = 1'b0;
    endtask

    task automatic resolve(input logic [c_TAG_W-1:0] tag, input logic mp);
        resolve_valid      = 1'b1;
        resolve_tag        = tag;
        resolve_mispredict = mp;
        step();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    initial begin
        rst = 1'b0; alloc_req = 1'b0; alloc_pc = '0;
        resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0;
        exception_sig = 1'b0; mret_sig = 1'b0;
        step(); step();

        // ---- reset state ----
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_copy", 32'(copy_rat), 32'd0);
        check("rst_paste", 32'(paste_rat), 32'd0);
        check("rst_busy", 32'(recover_busy), 32'd0);
        check("rst_oldest", oldest_pc, 32'd0);
        check("rst_err", 32'(resolve_err), 32'd0);
        rst = 1'b1;
        step();

        // ---- 1: three allocations ----
        for (int k = 0; k < 3; k++) begin
            alloc_req = 1'b1;
            alloc_pc  = 32'h100 + 32'(4 * k);
            #1;
            check("t1_grant", 32'(alloc_grant), 32'd1);
            check("t1_tag", 32'(alloc_tag), 32'(k));
            @(posedge clk); #1;
            check("t1_copy", 32'(copy_rat), 32'd1);
            check("t1_copytag", 32'(copy_tag), 32'(k));
        end
        alloc_req = 1'b0;
        check("t1_count", 32'(count), 32'd3);
        check("t1_oldest", oldest_pc, 32'h100);
        step();
        check("t1_copy_off", 32'(copy_rat), 32'd0);

        // ---- 2: out-of-order correct resolves, in-order retire ----
        resolve(3'd1, 1'b0);
        check("t2_cnt_a", 32'(count), 32'd3);
        resolve(3'd0, 1'b0);
        check("t2_cnt_b", 32'(count), 32'd3);
        step();
        check("t2_cnt_c", 32'(count), 32'd2);
        check("t2_old_c", oldest_pc, 32'h104);
        step();
        check("t2_cnt_d", 32'(count), 32'd1);
        check("t2_old_d", oldest_pc, 32'h108);

        // ---- 3: full ring and wrap ----
        do_reset();
        alloc_n(8, 32'h200);
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd8);
        alloc_req = 1'b1;
        #1;
        check("t3_nogrant", 32'(alloc_grant), 32'd0);
        alloc_req = 1'b0;
        resolve(3'd0, 1'b0);
        check("t3_full_hold", 32'(full), 32'd1);
        step();
        check("t3_full_drop", 32'(full), 32'd0);
        check("t3_count7", 32'(count), 32'd7);
        alloc_req = 1'b1;
        alloc_pc  = 32'h300;
        #1;
        check("t3_wrap_grant", 32'(alloc_grant), 32'd1);
        check("t3_wrap_tag", 32'(alloc_tag), 32'd0);
        step();
        alloc_req = 1'b0;
        check("t3_refull", 32'(full), 32'd1);

        // ---- 4: mispredict on tag 2 with tags 0..4 live ----
        do_reset();
        alloc_n(5, 32'h400);
        resolve_valid      = 1'b1;
        resolve_tag        = 3'd2;
        resolve_mispredict = 1'b1;
        alloc_req          = 1'b1;
        #1;
        check("t4_mp_block", 32'(alloc_grant), 32'd0);
        step();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
        #1;
        check("t4_paste", 32'(paste_rat), 32'd1);
        check("t4_ptag", 32'(paste_tag), 32'd2);
        check("t4_mask", 32'(flush_mask), 32'h18);
        check("t4_count", 32'(count), 32'd2);
        check("t4_tail", 32'(alloc_tag), 32'd2);
        check("t4_busy1", 32'(recover_busy), 32'd1);
        check("t4_nocopy", 32'(copy_rat), 32'd0);
        check("t4_busy_nogrant", 32'(alloc_grant), 32'd0);
        step();
        check("t4_paste_off", 32'(paste_rat), 32'd0);
        check("t4_busy2", 32'(recover_busy), 32'd1);
        check("t4_mask_off", 32'(flush_mask), 32'd0);
        check("t4_busy_nogrant2", 32'(alloc_grant), 32'd0);
        step();
        check("t4_idle", 32'(recover_busy), 32'd0);
        check("t4_grant_again", 32'(alloc_grant), 32'd1);
        step();
        alloc_req = 1'b0;
        check("t4_copytag", 32'(copy_tag), 32'd2);
        check("t4_count3", 32'(count), 32'd3);

        // ---- 5: alloc + mispredict + exception together ----
        alloc_req          = 1'b1;
        alloc_pc           = 32'h500;
        resolve_valid      = 1'b1;
        resolve_tag        = 3'd1;
        resolve_mispredict = 1'b1;
        exception_sig      = 1'b1;
        #1;
        check("t5_nogrant", 32'(alloc_grant), 32'd0);
        step();
        alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0; exception_sig = 1'b0;
        #1;
        check("t5_nopaste", 32'(paste_rat), 32'd0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_tail", 32'(alloc_tag), 32'd0);
        check("t5_busy", 32'(recover_busy), 32'd0);
        check("t5_oldest", oldest_pc, 32'd0);
        alloc_n(1, 32'h600);
        check("t5_head0", oldest_pc, 32'h600);

        // ---- 6: bad resolve, then async reset during recovery ----
        resolve(3'd5, 1'b0);
        check("t6_err", 32'(resolve_err), 32'd1);
        check("t6_count", 32'(count), 32'd1);
        check("t6_oldest", oldest_pc, 32'h600);
        resolve(3'd0, 1'b1);
        check("t6_busy", 32'(recover_busy), 32'd1);
        check("t6_paste", 32'(paste_rat), 32'd1);
        check("t6_mask", 32'(flush_mask), 32'd0);
        check("t6_count0", 32'(count), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_arst_busy", 32'(recover_busy), 32'd0);
        check("t6_arst_paste", 32'(paste_rat), 32'd0);
        check("t6_arst_err", 32'(resolve_err), 32'd0);
        check("t6_arst_count", 32'(count), 32'd0);
        step();
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
